// File: rtl/ascon_pack.sv
// ---------------------------------------------------------------------------
// ascon_pack: shared ASCON types and constants, and the rate padding helper
// used by the absorb stage (and later by the squeeze stage).
//   type_state : 5 x 64-bit ASCON state, word 0 first (state[0:1] is the
//                128-bit rate with state[0] in the upper half).
//   rate_pad() : applies last-block 10* padding to a left-aligned block.
// ---------------------------------------------------------------------------
package ascon_pack;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned NUM_WORDS  = 5;
    localparam int unsigned KEY_W      = 128;
    localparam int unsigned MAX_RATE_W = 128;
    localparam int unsigned MAX_RATE_B = MAX_RATE_W / 8;

    typedef logic [0:NUM_WORDS-1][WORD_W-1:0] type_state;

    // ASCON-128 / ASCON-128a initialisation vectors
    localparam logic [WORD_W-1:0] IV_ASCON128  = 64'h80400c0600000000;
    localparam logic [WORD_W-1:0] IV_ASCON128A = 64'h80800c0800000000;

    // First byte of padding after the last message byte
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        ABS_IDLE = 2'd0,
        ABS_DATA = 2'd1,
        ABS_OUT  = 2'd2
    } absorb_fsm_e;

    // Block is left-aligned in 128 bits (byte 0 = bits 127:120). Narrower
    // rates place their block in the top bytes; any pad byte landing beyond
    // the caller's rate is simply dropped by the caller, which makes a full
    // narrow block and an oversized byte count behave as "no padding".
    function automatic logic [MAX_RATE_W-1:0] rate_pad(
        input logic [MAX_RATE_W-1:0] data,
        input logic [4:0]            nbytes,
        input logic                  last
    );
        logic [MAX_RATE_W-1:0] res;
        logic [4:0]            n;
        res = data;
        n   = (nbytes > 5'(MAX_RATE_B)) ? 5'(MAX_RATE_B) : nbytes;
        if (last) begin
            for (int unsigned b = 0; b < MAX_RATE_B; b++) begin
                if (5'(b) > n) begin
                    res[MAX_RATE_W-1-8*b -: 8] = 8'h00;
                end else if (5'(b) == n) begin
                    res[MAX_RATE_W-1-8*b -: 8] = PAD_BYTE;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xor_absorb_pad.sv
// ---------------------------------------------------------------------------
// xor_absorb_pad: combinational last-block padding of one rate block.
//   data_i       : RATE_W-bit block, byte 0 = MSB
//   bytes_i      : valid bytes (only meaningful with last_i)
//   last_i       : block is the final one of the message
//   data_pad_c_o : padded block (combinational)
// ---------------------------------------------------------------------------
module xor_absorb_pad
    import ascon_pack::*;
#(
    parameter int unsigned RATE_W = 64
) (
    input  logic [RATE_W-1:0]          data_i,
    input  logic [$clog2(RATE_W/8):0]  bytes_i,
    input  logic                       last_i,
    output logic [RATE_W-1:0]          data_pad_c_o
);

    logic [MAX_RATE_W-1:0] data_wide;

    // Left-align the block so the shared 128-bit helper sees byte 0 on top
    assign data_wide    = MAX_RATE_W'(data_i) << (MAX_RATE_W - RATE_W);
    assign data_pad_c_o = RATE_W'(rate_pad(data_wide, 5'(bytes_i), last_i)
                                  >> (MAX_RATE_W - RATE_W));

endmodule

// File: rtl/xor_absorb.sv
// ---------------------------------------------------------------------------
// xor_absorb: registered begin-of-round XOR stage in front of the ASCON
// permutation. Captures a state, applies key/dom-sep XOR, optionally absorbs
// one padded rate block, and hands the result downstream.
//   clock_i, reset_i               : clock, sync active-high reset
//   state_i/_valid_i/_ready_o      : input state handshake (+ en_* / key_i)
//   data_i/_bytes_i/_last_i/_valid_i/_ready_o : data block handshake
//   state_o/_valid_o/_ready_i      : output state handshake
//   block_cnt_o                    : data blocks absorbed in current message
// ---------------------------------------------------------------------------
module xor_absorb
    import ascon_pack::*;
#(
    parameter int unsigned RATE_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  type_state                  state_i,
    input  logic                       state_valid_i,
    output logic                       state_ready_o,
    input  logic                       en_xor_data_i,
    input  logic                       en_xor_key_i,
    input  logic                       en_dom_sep_i,
    input  logic [KEY_W-1:0]           key_i,
    input  logic [RATE_W-1:0]          data_i,
    input  logic [$clog2(RATE_W/8):0]  data_bytes_i,
    input  logic                       data_last_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o,
    output type_state                  state_o,
    output logic                       state_valid_o,
    input  logic                       state_ready_i,
    output logic [CNT_W-1:0]           block_cnt_o
);

    absorb_fsm_e       fsm_q, fsm_d;
    type_state         state_q, state_d;
    logic              state_ready_q, state_ready_d;
    logic              data_ready_q, data_ready_d;
    logic              state_valid_q, state_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              restart_q, restart_d;
    logic [RATE_W-1:0] data_pad_c;
    logic              st_hs, data_hs, out_hs;

    // Ready/valid flags are only high in their own FSM state, so stray
    // inputs in the other states never form a handshake.
    assign st_hs   = state_valid_i & state_ready_q;
    assign data_hs = data_valid_i  & data_ready_q;
    assign out_hs  = state_ready_i & state_valid_q;

    xor_absorb_pad #(
        .RATE_W (RATE_W)
    ) u_pad (
        .data_i       (data_i),
        .bytes_i      (data_bytes_i),
        .last_i       (data_last_i),
        .data_pad_c_o (data_pad_c)
    );

    // FSM state register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q <= ABS_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ABS_IDLE: if (st_hs)   fsm_d = en_xor_data_i ? ABS_DATA : ABS_OUT;
            ABS_DATA: if (data_hs) fsm_d = ABS_OUT;
            ABS_OUT:  if (out_hs)  fsm_d = ABS_IDLE;
            default:               fsm_d = ABS_IDLE;
        endcase
    end

    // Handshake flags decoded from the next state, then registered
    always_comb begin
        state_ready_d = 1'b0;
        data_ready_d  = 1'b0;
        state_valid_d = 1'b0;
        case (fsm_d)
            ABS_IDLE: state_ready_d = 1'b1;
            ABS_DATA: data_ready_d  = 1'b1;
            ABS_OUT:  state_valid_d = 1'b1;
            default:  state_ready_d = 1'b0;
        endcase
    end

    // State datapath: key/dom-sep on capture, rate XOR on data absorb
    always_comb begin
        state_d = state_q;
        if (st_hs) begin
            state_d = state_i;
            if (en_xor_key_i) begin
                state_d[3] = state_i[3] ^ key_i[KEY_W-1 -: WORD_W];
                state_d[4] = state_i[4] ^ key_i[WORD_W-1:0];
            end
            if (en_dom_sep_i) begin
                state_d[4][0] = ~state_d[4][0];
            end
        end else if (data_hs) begin
            state_d[0] = state_q[0] ^ data_pad_c[RATE_W-1 -: WORD_W];
            if (RATE_W == 2 * WORD_W) begin
                state_d[1] = state_q[1] ^ data_pad_c[WORD_W-1:0];
            end
        end
    end

    // Block counter: restarts at 1 on the first block after a last block
    always_comb begin
        cnt_d     = cnt_q;
        restart_d = restart_q;
        if (data_hs) begin
            restart_d = data_last_i;
            if (restart_q) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output and datapath registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= '0;
            state_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
            state_valid_q <= 1'b0;
            cnt_q         <= '0;
            restart_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            state_ready_q <= state_ready_d;
            data_ready_q  <= data_ready_d;
            state_valid_q <= state_valid_d;
            cnt_q         <= cnt_d;
            restart_q     <= restart_d;
        end
    end

    assign state_o       = state_q;
    assign state_ready_o = state_ready_q;
    assign data_ready_o  = data_ready_q;
    assign state_valid_o = state_valid_q;
    assign block_cnt_o   = cnt_q;

endmodule

// File: tb/tb_xor_absorb.sv
`timescale 1ns/1ps
module tb_xor_absorb;
    import ascon_pack::*;

    typedef struct {
        type_state   st;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 128-bit rate instance
    type_state     a_state_i, a_state_o;
    logic          a_sv_i, a_sr_o, a_xd, a_xk, a_ds, a_last, a_dv, a_dr_o, a_svo, a_sri;
    logic [127:0]  a_key, a_data;
    logic [4:0]    a_bytes;
    logic [15:0]   a_cnt;

    // 64-bit rate instance with a 2-bit counter to reach saturation
    type_state     b_state_i, b_state_o;
    logic          b_sv_i, b_sr_o, b_xd, b_xk, b_ds, b_last, b_dv, b_dr_o, b_svo, b_sri;
    logic [127:0]  b_key;
    logic [63:0]   b_data;
    logic [3:0]    b_bytes;
    logic [1:0]    b_cnt;

    xor_absorb #(.RATE_W(128), .CNT_W(16)) dut_a (
        .clock_i(clk), .reset_i(rst),
        .state_i(a_state_i), .state_valid_i(a_sv_i), .state_ready_o(a_sr_o),
        .en_xor_data_i(a_xd), .en_xor_key_i(a_xk), .en_dom_sep_i(a_ds), .key_i(a_key),
        .data_i(a_data), .data_bytes_i(a_bytes), .data_last_i(a_last),
        .data_valid_i(a_dv), .data_ready_o(a_dr_o),
        .state_o(a_state_o), .state_valid_o(a_svo), .state_ready_i(a_sri),
        .block_cnt_o(a_cnt));

    xor_absorb #(.RATE_W(64), .CNT_W(2)) dut_b (
        .clock_i(clk), .reset_i(rst),
        .state_i(b_state_i), .state_valid_i(b_sv_i), .state_ready_o(b_sr_o),
        .en_xor_data_i(b_xd), .en_xor_key_i(b_xk), .en_dom_sep_i(b_ds), .key_i(b_key),
        .data_i(b_data), .data_bytes_i(b_bytes), .data_last_i(b_last),
        .data_valid_i(b_dv), .data_ready_o(b_dr_o),
        .state_o(b_state_o), .state_valid_o(b_svo), .state_ready_i(b_sri),
        .block_cnt_o(b_cnt));

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   cnt_a = 0, cnt_b = 0;
    bit   rs_a = 0, rs_b = 0;

    localparam type_state S = {64'h82BF91294BA5808D, 64'hD81EECA694136F8A,
                               64'h0217BC9EBD9FFF02, 64'h2163C2A59353D4C8,
                               64'h2731CDA0E76AA05B};
    localparam logic [127:0] K = 128'h691AED630E81901F6CB10AD9CA912F80;
    localparam logic [127:0] D = 128'h6F74206563696C4100000001626F4220;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 320'(act), 320'(exp));
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference: byte-wise absorb of the rate bytes with 10* padding
    function automatic type_state model(input type_state s, input bit xd, input bit xk,
                                        input bit ds, input logic [127:0] key,
                                        input logic [127:0] data, input int rb,
                                        input int nb, input bit last);
        type_state  r;
        logic [7:0] by;
        int         n;
        r = s;
        if (xk) begin
            r[3] = r[3] ^ key[127:64];
            r[4] = r[4] ^ key[63:0];
        end
        if (ds) r[4][0] = ~r[4][0];
        if (xd) begin
            n = (nb > rb) ? rb : nb;
            for (int b = 0; b < rb; b++) begin
                by = data[8*(rb-1-b) +: 8];
                if (last && n < rb && b >= n) by = (b == n) ? 8'h80 : 8'h00;
                r[b/8][63-8*(b%8) -: 8] = r[b/8][63-8*(b%8) -: 8] ^ by;
            end
        end
        return r;
    endfunction

    function automatic int next_cnt(input int c, input bit restart, input int maxv);
        if (restart) return 1;
        return (c >= maxv) ? maxv : c + 1;
    endfunction

    // Scoreboard monitors: compare on each output handshake
    always @(negedge clk) begin
        if (!rst && a_svo && a_sri) begin
            if (q_a.size() == 0) begin
                timeout("a_unexpected_output");
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_state_o", a_state_o, e.st);
                chk("a_block_cnt", 320'(a_cnt), 320'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_svo && b_sri) begin
            if (q_b.size() == 0) begin
                timeout("b_unexpected_output");
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_state_o", b_state_o, e.st);
                chk("b_block_cnt", 320'(b_cnt), 320'(e.cnt));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic txn_a(input type_state s, input bit xd, input bit xk, input bit ds,
                         input logic [127:0] key, input logic [127:0] data,
                         input logic [4:0] nb, input bit last, input type_state exp_st,
                         input int stall);
        exp_t e;
        int   k;
        if (xd) begin
            cnt_a = next_cnt(cnt_a, rs_a, 65535);
            rs_a  = last;
        end
        e.st = exp_st;
        e.cnt = 16'(cnt_a);
        q_a.push_back(e);
        a_state_i = s; a_xd = xd; a_xk = xk; a_ds = ds; a_key = key; a_sv_i = 1'b1;
        k = 0;
        while (!a_sr_o && k < 20) begin tick(); k++; end
        if (k == 20) timeout("a_state_ready_wait");
        tick();
        a_sv_i = 1'b0;
        a_state_i = {5{$urandom, $urandom}};
        a_xk = 1'($urandom); a_ds = 1'($urandom); a_key = {4{$urandom}};
        if (xd) begin
            chk1("a_data_ready_latency", a_dr_o, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
            a_data = data; a_bytes = nb; a_last = last; a_dv = 1'b1;
            k = 0;
            while (!a_dr_o && k < 20) begin tick(); k++; end
            if (k == 20) timeout("a_data_ready_wait");
            tick();
            a_dv = 1'b0;
            a_data = {4{$urandom}};
            chk1("a_data_ready_drop", a_dr_o, 1'b0);
        end
        chk1("a_valid_latency", a_svo, 1'b1);
        for (int i = 0; i < stall; i++) begin
            a_sv_i = ~a_sv_i;
            a_dv   = ~a_dv;
            tick();
            chk1("a_stall_valid", a_svo, 1'b1);
            chk1("a_stall_state_ready", a_sr_o, 1'b0);
            chk1("a_stall_data_ready", a_dr_o, 1'b0);
            chk("a_stall_state_o", a_state_o, exp_st);
        end
        a_sv_i = 1'b0;
        a_dv   = 1'b0;
        a_sri  = 1'b1;
        tick();
        a_sri = 1'b0;
        chk1("a_ready_after_out", a_sr_o, 1'b1);
    endtask

    task automatic txn_b(input type_state s, input bit xd, input logic [63:0] data,
                         input logic [3:0] nb, input bit last, input type_state exp_st);
        exp_t e;
        int   k;
        if (xd) begin
            cnt_b = next_cnt(cnt_b, rs_b, 3);
            rs_b  = last;
        end
        e.st = exp_st;
        e.cnt = 16'(cnt_b);
        q_b.push_back(e);
        b_state_i = s; b_xd = xd; b_xk = 1'b0; b_ds = 1'b0; b_sv_i = 1'b1;
        k = 0;
        while (!b_sr_o && k < 20) begin tick(); k++; end
        if (k == 20) timeout("b_state_ready_wait");
        tick();
        b_sv_i = 1'b0;
        if (xd) begin
            b_data = data; b_bytes = nb; b_last = last; b_dv = 1'b1;
            tick();
            b_dv = 1'b0;
        end
        k = 0;
        while (!b_svo && k < 20) begin tick(); k++; end
        if (k == 20) timeout("b_valid_wait");
        b_sri = 1'b1;
        tick();
        b_sri = 1'b0;
    endtask

    initial begin
        type_state    zs, rs;
        logic [127:0] rk, rdat;
        logic [63:0]  bd;
        bit           xd, xk, ds, last;
        logic [4:0]   nb;
        logic [3:0]   bnb;
        int           k;

        zs = '0;
        a_state_i = '0; a_sv_i = 0; a_xd = 0; a_xk = 0; a_ds = 0; a_key = '0;
        a_data = '0; a_bytes = '0; a_last = 0; a_dv = 0; a_sri = 0;
        b_state_i = '0; b_sv_i = 0; b_xd = 0; b_xk = 0; b_ds = 0; b_key = '0;
        b_data = '0; b_bytes = '0; b_last = 0; b_dv = 0; b_sri = 0;

        // Reset values, including ready low during the reset cycle
        rst = 1'b1;
        tick();
        chk1("rst_state_ready", a_sr_o, 1'b0);
        chk1("rst_state_valid", a_svo, 1'b0);
        chk1("rst_data_ready", a_dr_o, 1'b0);
        chk("rst_block_cnt", 320'(a_cnt), 320'(0));
        chk("rst_state_o", a_state_o, 320'(0));
        rst = 1'b0;
        tick();
        chk1("post_rst_state_ready", a_sr_o, 1'b1);

        // Directed vectors
        txn_a(S, 0, 0, 0, K, D, 5'd0, 0, S, 0);
        txn_a(S, 1, 0, 0, K, D, 5'd0, 0,
              {64'hEDCBB14C28CCECCC, 64'hD81EECA7F67C2DAA, S[2], S[3], S[4]}, 0);
        txn_a(S, 0, 1, 1, K, D, 5'd0, 0,
              {S[0], S[1], S[2], 64'h48792FC69DD244D7, 64'h4B80C7792DFB8FDA}, 0);
        txn_a(S, 1, 1, 0, K, D, 5'd16, 1, model(S, 1, 1, 0, K, D, 16, 16, 1), 5);
        txn_a(S, 1, 0, 1, K, D, 5'd0, 1, model(S, 1, 0, 1, K, D, 16, 0, 1), 0);
        txn_a(S, 1, 0, 0, K, D, 5'd31, 1, model(S, 1, 0, 0, K, D, 16, 31, 1), 0);

        // 64-bit rate: padding, restart, saturation, clamp
        txn_b(zs, 1, 64'hAABBCC0000000000, 4'd3, 1,
              {64'hAABBCC8000000000, 64'h0, 64'h0, 64'h0, 64'h0});
        for (int i = 0; i < 8; i++) begin
            rs  = {5{$urandom, $urandom}};
            bd  = {$urandom, $urandom};
            bnb = 4'($urandom_range(0, 15));
            last = (i == 4) || (i == 6);
            txn_b(rs, 1, bd, bnb, last, model(rs, 1, 0, 0, '0, {64'h0, bd}, 8, int'(bnb), last));
        end
        txn_b(S, 0, 64'h0, 4'd0, 0, S);

        // Randomized 128-bit rate traffic
        for (int i = 0; i < 40; i++) begin
            rs   = {5{$urandom, $urandom}};
            rk   = {4{$urandom}};
            rdat = {4{$urandom}};
            xd   = 1'($urandom);
            xk   = 1'($urandom);
            ds   = 1'($urandom);
            last = 1'($urandom);
            nb   = 5'($urandom_range(0, 31));
            txn_a(rs, xd, xk, ds, rk, rdat, nb, last,
                  model(rs, xd, xk, ds, rk, rdat, 16, int'(nb), last), $urandom_range(0, 2));
        end

        // Reset while waiting for data: held state must never emerge
        a_state_i = S; a_xd = 1; a_xk = 1; a_ds = 0; a_key = K; a_sv_i = 1'b1;
        k = 0;
        while (!a_sr_o && k < 20) begin tick(); k++; end
        if (k == 20) timeout("a_reset_ready_wait");
        tick();
        a_sv_i = 1'b0;
        chk1("pre_reset_data_ready", a_dr_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("mid_rst_state_valid", a_svo, 1'b0);
        chk1("mid_rst_data_ready", a_dr_o, 1'b0);
        chk1("mid_rst_state_ready", a_sr_o, 1'b0);
        chk("mid_rst_block_cnt", 320'(a_cnt), 320'(0));
        tick();
        chk1("after_rst_state_ready", a_sr_o, 1'b1);
        chk1("after_rst_state_valid", a_svo, 1'b0);
        cnt_a = 0; rs_a = 0; cnt_b = 0; rs_b = 0;
        repeat (3) tick();
        txn_a(S, 0, 0, 0, K, D, 5'd0, 0, S, 0);
        txn_a(zs, 1, 0, 0, K, D, 5'd2, 1, model(zs, 1, 0, 0, K, D, 16, 2, 1), 1);

        repeat (4) tick();
        chk("a_queue_drained", 320'(q_a.size()), 320'(0));
        chk("b_queue_drained", 320'(q_b.size()), 320'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
